// File: rtl/openfire_fetch_pf_if.sv
`default_nettype none
// ============================================================================
// Module   : openfire_fetch_pf_if
// Brief    : Instruction-memory req/ack bus between fetch and memory
// Revision : 1.0
// ============================================================================
interface openfire_fetch_pf_if ();
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] idata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  idata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output idata
    );
endinterface
`default_nettype wire

// File: rtl/openfire_fetch_pf.sv
`default_nettype none
// ============================================================================
// Module   : openfire_fetch_pf
// Brief    : Fetch stage with a {pc, instruction} prefetch FIFO feeding DECODE
// Revision : 1.0
// ============================================================================
module openfire_fetch_pf #(
    parameter int                 A_SPACE   = 16,
    parameter int                 PF_DEPTH  = 4,
    parameter logic [A_SPACE+1:0] RESET_PC  = '0,
    parameter logic [31:0]        NOP_INSTR = 32'h80000000
) (
    input  wire logic                       clock,
    input  wire logic                       reset,
    input  wire logic                       stall,
    input  wire logic                       branch_taken,
    input  wire logic [A_SPACE+1:0]         pc_branch,
    openfire_fetch_pf_if.master             imem,
    output logic [31:0]                     instruction,
    output logic [A_SPACE+1:0]              pc_decode,
    output logic                            instr_valid,
    output logic [$clog2(PF_DEPTH):0]       pf_count
);

    localparam int                 c_ptr_w = $clog2(PF_DEPTH);
    localparam int                 c_cnt_w = c_ptr_w + 1;
    localparam int                 c_pc_w  = A_SPACE + 2;
    localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(PF_DEPTH);

    logic [c_pc_w-1:0]  fifo_pc_q   [PF_DEPTH];
    logic [c_pc_w-1:0]  fifo_pc_d   [PF_DEPTH];
    logic [31:0]        fifo_data_q [PF_DEPTH];
    logic [31:0]        fifo_data_d [PF_DEPTH];
    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0] count_q, count_d;
    logic [c_pc_w-1:0]  pc_fetch_q, pc_fetch_d;
    logic [c_pc_w-1:0]  pc_decode_q, pc_decode_d;
    logic [31:0]        instruction_q, instruction_d;
    logic               instr_valid_q, instr_valid_d;
    logic               req_q, req_d;
    logic               discard_q, discard_d;
    logic [A_SPACE-1:0] addr_q, addr_d;

    logic               w_accept;
    logic               w_pending;
    logic               w_branch;
    logic               w_push;
    logic               w_pop;
    logic [31:0]        w_addr_ext;

    assign w_accept  = req_q & imem.imem_ack;
    assign w_pending = req_q & ~imem.imem_ack;
    assign w_branch  = branch_taken & ~stall;
    assign w_push    = w_accept & ~discard_q & ~w_branch;
    assign w_pop     = ~stall & ~w_branch & (count_q != '0);

    always_comb begin
        fifo_pc_d     = fifo_pc_q;
        fifo_data_d   = fifo_data_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        pc_fetch_d    = pc_fetch_q;
        pc_decode_d   = pc_decode_q;
        instruction_d = instruction_q;
        instr_valid_d = instr_valid_q;
        discard_d     = discard_q;
        req_d         = req_q;
        addr_d        = addr_q;

        // DECODE side reads the head before this cycle's push lands.
        if (w_branch) begin
            instruction_d = NOP_INSTR;
            instr_valid_d = 1'b0;
        end else if (!stall) begin
            if (count_q != '0) begin
                instruction_d = fifo_data_q[rd_ptr_q];
                pc_decode_d   = fifo_pc_q[rd_ptr_q];
                instr_valid_d = 1'b1;
            end else begin
                instruction_d = NOP_INSTR;
                instr_valid_d = 1'b0;
            end
        end

        if (w_push) begin
            fifo_pc_d[wr_ptr_q]   = pc_fetch_q;
            fifo_data_d[wr_ptr_q] = imem.idata;
            wr_ptr_d              = wr_ptr_q + c_ptr_w'(1);
            pc_fetch_d            = pc_fetch_q + c_pc_w'(4);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_cnt_w'(1);
            2'b01:   count_d = count_q - c_cnt_w'(1);
            default: count_d = count_q;
        endcase

        if (w_accept) begin
            discard_d = 1'b0;
        end

        if (w_branch) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            pc_fetch_d = pc_branch & ~c_pc_w'(3);
            // The in-flight response belongs to the old stream; swallow it.
            if (w_pending) begin
                discard_d = 1'b1;
            end
        end

        // A pending request keeps its address; otherwise issue from the new PC.
        if (w_pending) begin
            req_d  = 1'b1;
            addr_d = addr_q;
        end else begin
            req_d  = (count_d < c_full);
            addr_d = pc_fetch_d[c_pc_w-1:2];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PF_DEPTH; i++) begin
                fifo_pc_q[i]   <= '0;
                fifo_data_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            pc_fetch_q    <= RESET_PC & ~c_pc_w'(3);
            pc_decode_q   <= '0;
            instruction_q <= NOP_INSTR;
            instr_valid_q <= 1'b0;
            discard_q     <= 1'b0;
            req_q         <= 1'b0;
            addr_q        <= RESET_PC[c_pc_w-1:2];
        end else begin
            fifo_pc_q     <= fifo_pc_d;
            fifo_data_q   <= fifo_data_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            pc_fetch_q    <= pc_fetch_d;
            pc_decode_q   <= pc_decode_d;
            instruction_q <= instruction_d;
            instr_valid_q <= instr_valid_d;
            discard_q     <= discard_d;
            req_q         <= req_d;
            addr_q        <= addr_d;
        end
    end

    always_comb begin
        w_addr_ext              = '0;
        w_addr_ext[A_SPACE-1:0] = addr_q;
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = w_addr_ext;
    assign instruction    = instruction_q;
    assign pc_decode      = pc_decode_q;
    assign instr_valid    = instr_valid_q;
    assign pf_count       = count_q;

endmodule
`default_nettype wire

// File: tb/tb_openfire_fetch_pf.sv
`default_nettype none
// ============================================================================
// Module   : tb_openfire_fetch_pf
// Brief    : Self-checking bench: queue-based reference model plus directed cases
// Revision : 1.0
// ============================================================================
module tb_openfire_fetch_pf;

    localparam int          A_SPACE  = 16;
    localparam int          PF_DEPTH = 4;
    localparam logic [31:0] NOP      = 32'h80000000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [17:0] pc_branch;
    logic [31:0] instruction;
    logic [17:0] pc_decode;
    logic        instr_valid;
    logic [2:0]  pf_count;

    logic        manual;
    logic        ack_man;
    logic        ack_auto;
    int          lat;
    int          waitc;
    int          cyc;
    int          n_checks;
    int          n_errors;

    openfire_fetch_pf_if mem_if ();

    assign mem_if.imem_ack = manual ? ack_man : ack_auto;
    assign mem_if.idata    = {16'hC0DE, mem_if.imem_addr[15:0]};

    openfire_fetch_pf #(
        .A_SPACE  (A_SPACE),
        .PF_DEPTH (PF_DEPTH)
    ) dut (
        .clock        (clk),
        .reset        (rst_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .pc_branch    (pc_branch),
        .imem         (mem_if),
        .instruction  (instruction),
        .pc_decode    (pc_decode),
        .instr_valid  (instr_valid),
        .pf_count     (pf_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory with a configurable response latency (0 = ack always high)
    always @(posedge clk) begin
        #1;
        if (lat == 0) begin
            ack_auto = 1'b1;
        end else if (mem_if.imem_req) begin
            if (waitc >= lat - 1) begin
                ack_auto = 1'b1;
                waitc    = 0;
            end else begin
                ack_auto = 1'b0;
                waitc    = waitc + 1;
            end
        end else begin
            ack_auto = 1'b0;
            waitc    = 0;
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: FIFO as a queue, fetch PC, outstanding request, discard flag
    typedef struct packed {
        logic [17:0] pc;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic [17:0] m_pcf;
    logic        m_req;
    logic [15:0] m_addr;
    logic        m_disc;
    logic [31:0] m_instr;
    logic [17:0] m_pcd;
    logic        m_valid;

    always @(negedge clk) begin
        logic acc, br, pend;
        ent_t e;
        if (!rst_n) begin
            mq.delete();
            m_pcf   = '0;
            m_req   = 1'b0;
            m_addr  = '0;
            m_disc  = 1'b0;
            m_instr = NOP;
            m_pcd   = '0;
            m_valid = 1'b0;
        end
        check("cycle_outputs",
              {41'd0, mem_if.imem_req, mem_if.imem_addr, instruction, pc_decode, instr_valid, pf_count},
              {41'd0, m_req, 16'd0, m_addr, m_instr, m_pcd, m_valid, 3'(mq.size())});
        if (rst_n) begin
            acc  = m_req && mem_if.imem_ack;
            pend = m_req && !mem_if.imem_ack;
            br   = branch_taken && !stall;
            if (br) begin
                mq.delete();
                m_instr = NOP;
                m_valid = 1'b0;
            end else if (!stall) begin
                if (mq.size() != 0) begin
                    e       = mq.pop_front();
                    m_instr = e.d;
                    m_pcd   = e.pc;
                    m_valid = 1'b1;
                end else begin
                    m_instr = NOP;
                    m_valid = 1'b0;
                end
            end
            if (acc) begin
                if (m_disc) m_disc = 1'b0;
                else if (!br) begin
                    mq.push_back('{pc: m_pcf, d: mem_if.idata});
                    m_pcf = m_pcf + 18'd4;
                end
            end
            if (br) begin
                m_pcf = {pc_branch[17:2], 2'b00};
                if (pend) m_disc = 1'b1;
            end
            if (pend) begin
                m_req = 1'b1;
            end else begin
                m_req  = (mq.size() < PF_DEPTH);
                m_addr = m_pcf[17:2];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input string name, output bit found);
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            tick();
            if (instr_valid) found = 1'b1;
        end
        check({name, "_timeout"}, 128'(found), 128'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit          found;
        int          t0;
        logic [17:0] exp_pc;
        n_checks = 0; n_errors = 0; cyc = 0; waitc = 0;
        rst_n = 1'b1; stall = 1'b0; branch_taken = 1'b0; pc_branch = '0;
        manual = 1'b0; ack_man = 1'b0; lat = 0; ack_auto = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        check("rst_req", 128'(mem_if.imem_req), 128'd0);
        check("rst_instr", 128'(instruction), 128'(NOP));
        rst_n = 1'b1;

        // Zero-wait memory: one instruction per cycle, 2-cycle ack-to-decode latency
        found = 1'b0;
        t0    = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (mem_if.imem_req && mem_if.imem_ack) begin
                found = 1'b1;
                t0    = cyc;
            end
        end
        check("first_req_timeout", 128'(found), 128'd1);
        check("first_addr", 128'(mem_if.imem_addr), 128'd0);
        tick();
        check("second_addr", 128'(mem_if.imem_addr), 128'd1);
        wait_valid("first_valid", found);
        check("ack_to_decode", 128'(cyc - t0), 128'd2);
        check("first_pcd", 128'(pc_decode), 128'd0);
        check("first_instr", 128'(instruction), 128'hC0DE0000);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("stream_pcd", 128'(pc_decode), 128'(4 * k));
        end

        // Stall: FIFO fills to depth, request drops, outputs frozen
        stall = 1'b1;
        repeat (10) tick();
        check("stall_count", 128'(pf_count), 128'd4);
        check("stall_req", 128'(mem_if.imem_req), 128'd0);
        check("stall_pcd", 128'(pc_decode), 128'd12);
        stall = 1'b0;
        tick();
        check("unstall_pcd0", 128'(pc_decode), 128'd16);
        check("unstall_req", 128'(mem_if.imem_req), 128'd1);
        check("unstall_count", 128'(pf_count), 128'd3);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("unstall_pcd", 128'(pc_decode), 128'(16 + 4 * k));
        end

        // 3-cycle memory latency: bubbles are NOPs, valid PCs strictly sequential
        lat    = 3;
        exp_pc = 18'd36;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (instr_valid) begin
                check("lat_pcd", 128'(pc_decode), 128'(exp_pc));
                exp_pc = exp_pc + 18'd4;
            end else begin
                check("lat_bubble", 128'(instruction), 128'h80000000);
            end
        end

        // Branch with a pending request whose ack comes late
        manual  = 1'b1;
        ack_man = 1'b0;
        repeat (6) tick();
        pc_branch = 18'h1C; branch_taken = 1'b1;
        tick();
        branch_taken = 1'b0; ack_man = 1'b1;
        tick();
        ack_man = 1'b0;
        check("word7_addr", 128'(mem_if.imem_addr), 128'd7);
        tick();
        pc_branch = 18'h100; branch_taken = 1'b1;
        tick();
        branch_taken = 1'b0;
        check("pending_addr_stable", 128'(mem_if.imem_addr), 128'd7);
        tick();
        ack_man = 1'b1;
        tick();
        ack_man = 1'b0;
        check("target_addr", 128'(mem_if.imem_addr), 128'h40);
        check("target_req", 128'(mem_if.imem_req), 128'd1);
        ack_man = 1'b1;
        wait_valid("target_valid", found);
        check("target_pcd", 128'(pc_decode), 128'h100);
        check("target_instr", 128'(instruction), 128'hC0DE0040);

        // Branch coincident with an accepted ack that would fill the FIFO
        stall = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (pf_count == 3'd3) found = 1'b1;
        end
        check("fill3_timeout", 128'(found), 128'd1);
        stall = 1'b0; pc_branch = 18'h200; branch_taken = 1'b1;
        tick();
        branch_taken = 1'b0;
        check("coinc_count", 128'(pf_count), 128'd0);
        check("coinc_addr", 128'(mem_if.imem_addr), 128'h80);
        check("coinc_valid", 128'(instr_valid), 128'd0);
        wait_valid("coinc_target", found);
        check("coinc_pcd", 128'(pc_decode), 128'h200);

        // PC wrap at the top of the address space
        ack_man = 1'b0;
        tick();
        pc_branch = 18'h3FFFC; branch_taken = 1'b1;
        tick();
        branch_taken = 1'b0; ack_man = 1'b1;
        tick();
        ack_man = 1'b0;
        check("top_addr", 128'(mem_if.imem_addr), 128'hFFFF);
        ack_man = 1'b1;
        tick();
        ack_man = 1'b0;
        check("wrap_addr", 128'(mem_if.imem_addr), 128'd0);

        // Asynchronous reset with a request to 0x3FFFC outstanding
        branch_taken = 1'b1;
        tick();
        branch_taken = 1'b0; ack_man = 1'b1;
        tick();
        ack_man = 1'b0;
        check("top_addr2", 128'(mem_if.imem_addr), 128'hFFFF);
        rst_n = 1'b0;
        #1;
        check("async_req", 128'(mem_if.imem_req), 128'd0);
        check("async_count", 128'(pf_count), 128'd0);
        check("async_pcd", 128'(pc_decode), 128'd0);
        check("async_valid", 128'(instr_valid), 128'd0);
        check("async_instr", 128'(instruction), 128'(NOP));
        check("async_addr", 128'(mem_if.imem_addr), 128'd0);
        ack_man = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_req", 128'(mem_if.imem_req), 128'd1);
        check("post_rst_addr", 128'(mem_if.imem_addr), 128'd0);
        check("late_ack_ignored", 128'(pf_count), 128'd0);
        wait_valid("post_rst_valid", found);
        check("post_rst_pcd", 128'(pc_decode), 128'd0);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
